// File: rtl/spm_arb_pkg.sv
// Shared definitions for the RISC_SPM memory arbiter: FSM encoding, requester IDs, default lock bound.
package spm_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  localparam logic REQ_CPU      = 1'b0;
  localparam logic REQ_LDR      = 1'b1;
  localparam int   MAX_LOCK_DEF = 4;

  function automatic arb_state_t own_state(input logic id);
    return id ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/spm_mem_arbiter_if.sv
// Requester and memory-port signals of the arbiter; slave = arbiter view, master = environment view.
interface spm_mem_arbiter_if #(
  parameter int word_size = 8,
  parameter int addr_size = 8
);

  logic                 req0, req1;
  logic                 lock0, lock1;
  logic                 we0, we1;
  logic [addr_size-1:0] addr0, addr1;
  logic [word_size-1:0] wdata0, wdata1;
  logic                 gnt0, gnt1;
  logic                 rvalid0, rvalid1;
  logic [word_size-1:0] rdata0, rdata1;
  logic                 mem_en, mem_we;
  logic [addr_size-1:0] mem_addr;
  logic [word_size-1:0] mem_wdata;
  logic [word_size-1:0] mem_rdata;

  modport slave (
    input  req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/spm_arb_lock_timer.sv
// Saturating count of locked accesses made while the other requester waits.
module spm_arb_lock_timer #(
  parameter int MAX_LOCK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_last,
  output logic o_expired
);

  localparam int CW = $clog2(MAX_LOCK + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_inc && !o_expired)
      r_cnt <= r_cnt + 1'b1;
  end

  // o_last: the locked access in flight now is the MAX_LOCK-th one
  assign o_expired = (r_cnt == CW'(MAX_LOCK));
  assign o_last    = (r_cnt >= CW'(MAX_LOCK - 1));

endmodule

// File: rtl/spm_mem_arbiter.sv
// Two-requester arbiter for the 256x8 RISC_SPM memory with bounded locked ownership.
// Define SPM_ARB_ROUND_ROBIN_EN for round-robin; otherwise the CPU has fixed priority.
module spm_mem_arbiter
  import spm_arb_pkg::*;
#(
  parameter int word_size = 8,
  parameter int addr_size = 8,
  parameter int MAX_LOCK  = MAX_LOCK_DEF
) (
  input logic              clk,
  input logic              rst,
  spm_mem_arbiter_if.slave bus
);

  arb_state_t           r_state, w_state_nxt;
  logic                 w_own0, w_own1, w_cur;
  logic                 w_req_n, w_lock_n, w_we_n, w_req_o, w_acc;
  logic                 w_lock_stay, w_win, w_last, w_expired, w_clr, w_inc;
  logic                 r_rd_pend_p1, r_rd_own_p1;
  logic [addr_size-1:0] w_addr;
  logic [word_size-1:0] w_wdata;

  assign w_own0   = (r_state == ST_OWN0);
  assign w_own1   = (r_state == ST_OWN1);
  assign w_cur    = w_own1 ? REQ_LDR : REQ_CPU;
  assign w_req_n  = w_own1 ? bus.req1  : bus.req0;
  assign w_lock_n = w_own1 ? bus.lock1 : bus.lock0;
  assign w_we_n   = w_own1 ? bus.we1   : bus.we0;
  assign w_req_o  = w_own1 ? bus.req0  : bus.req1;
  assign w_acc    = (w_own0 & bus.req0) | (w_own1 & bus.req1);

  assign w_lock_stay = w_req_n & w_lock_n & ~(w_last | w_expired);

`ifdef SPM_ARB_ROUND_ROBIN_EN
  logic r_rr, w_rr_nxt;

  // Preference is taken after this cycle's access so unlocked contenders alternate
  assign w_rr_nxt = r_rr ^ w_acc;
  assign w_win    = w_rr_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_rr <= REQ_CPU;
    else
      r_rr <= w_rr_nxt;
  end
`else
  assign w_win = REQ_CPU;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.req0 && bus.req1)
          w_state_nxt = own_state(w_win);
        else if (bus.req0)
          w_state_nxt = ST_OWN0;
        else if (bus.req1)
          w_state_nxt = ST_OWN1;
      end
      ST_OWN0, ST_OWN1: begin
        if (w_lock_stay)
          w_state_nxt = r_state;
        else if (w_req_o) begin
          // A locked owner that used up its budget is handed off without arbitration
          if (w_req_n && !w_lock_n)
            w_state_nxt = own_state(w_win);
          else
            w_state_nxt = own_state(~w_cur);
        end else if (!w_req_n)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_clr = (r_state == ST_IDLE) | (w_state_nxt != r_state) | ~w_req_o;
  assign w_inc = w_acc & w_lock_n & w_req_o;

  spm_arb_lock_timer #(
    .MAX_LOCK (MAX_LOCK)
  ) u_lock_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_clr),
    .i_inc     (w_inc),
    .o_last    (w_last),
    .o_expired (w_expired)
  );

  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    if (w_own0) begin
      w_addr  = bus.addr0;
      w_wdata = bus.wdata0;
    end else if (w_own1) begin
      w_addr  = bus.addr1;
      w_wdata = bus.wdata1;
    end
  end

  assign bus.mem_en    = w_acc;
  assign bus.mem_we    = w_acc & w_we_n;
  assign bus.mem_addr  = w_addr;
  assign bus.mem_wdata = w_wdata;

  // Stage p0 -> p1: remember who issued the read so the response follows it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_pend_p1 <= 1'b0;
      r_rd_own_p1  <= REQ_CPU;
    end else begin
      r_rd_pend_p1 <= w_acc & ~w_we_n;
      if (w_acc && !w_we_n)
        r_rd_own_p1 <= w_cur;
    end
  end

  assign bus.gnt0    = w_own0;
  assign bus.gnt1    = w_own1;
  assign bus.rvalid0 = r_rd_pend_p1 & (r_rd_own_p1 == REQ_CPU);
  assign bus.rvalid1 = r_rd_pend_p1 & (r_rd_own_p1 == REQ_LDR);
  assign bus.rdata0  = bus.mem_rdata;
  assign bus.rdata1  = bus.mem_rdata;

endmodule

// File: tb/tb_spm_mem_arbiter.sv
// Scoreboard bench for spm_mem_arbiter: directed vectors push expected accesses/responses, a monitor checks them.
module tb_spm_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spm_mem_arbiter_if #(.word_size(8), .addr_size(8)) bus ();

  spm_mem_arbiter #(
    .word_size (8),
    .addr_size (8),
    .MAX_LOCK  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       who;
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } acc_t;

  typedef struct packed {
    logic       who;
    logic [7:0] data;
  } rd_t;

  acc_t exp_acc[$];
  rd_t  exp_rd[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  // Memory model: default contents mem[i]=i, mem[129]=2, reloaded on every reset
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
      mem[129] <= 8'd2;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    n_cmp++;
    n_mis++;
    $display("FAIL %s: event seen, nothing expected", nm);
  endtask

  task automatic push_acc(input logic who, input logic we, input logic [7:0] a, input logic [7:0] d);
    acc_t e;
    e.who = who; e.we = we; e.addr = a; e.data = d;
    exp_acc.push_back(e);
  endtask

  task automatic push_rd(input logic who, input logic [7:0] d);
    rd_t e;
    e.who = who; e.data = d;
    exp_rd.push_back(e);
  endtask

  task automatic drive(input logic r0, input logic l0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                       input logic r1, input logic l1, input logic w1, input logic [7:0] a1, input logic [7:0] d1);
    bus.req0 = r0; bus.lock0 = l0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = r1; bus.lock1 = l1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
  endtask

  task automatic cyc(input logic r0, input logic l0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                     input logic r1, input logic l1, input logic w1, input logic [7:0] a1, input logic [7:0] d1);
    drive(r0, l0, w0, a0, d0, r1, l1, w1, a1, d1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 8'd0, 8'd0, 0, 0, 0, 8'd0, 8'd0);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 8'd0, 8'd0, 0, 0, 0, 8'd0, 8'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt0"},      bus.gnt0,      0);
    chk({tag, "_gnt1"},      bus.gnt1,      0);
    chk({tag, "_rvalid0"},   bus.rvalid0,   0);
    chk({tag, "_rvalid1"},   bus.rvalid1,   0);
    chk({tag, "_mem_en"},    bus.mem_en,    0);
    chk({tag, "_mem_we"},    bus.mem_we,    0);
    chk({tag, "_mem_addr"},  bus.mem_addr,  0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
  endtask

  // Monitor: every access and every read response must match the head of its queue
  always @(negedge clk) begin
    if (!rst) begin
      chk("gnt_overlap", bus.gnt0 & bus.gnt1, 0);
      if (bus.mem_en) begin
        if (exp_acc.size() == 0) miss("acc_unexpected");
        else begin
          acc_t e;
          e = exp_acc.pop_front();
          chk("acc_who",  bus.gnt1,     e.who);
          chk("acc_we",   bus.mem_we,   e.we);
          chk("acc_addr", bus.mem_addr, e.addr);
          if (e.we) chk("acc_wdata", bus.mem_wdata, e.data);
        end
      end
      if (bus.rvalid0 || bus.rvalid1) begin
        if (exp_rd.size() == 0) miss("rd_unexpected");
        else begin
          rd_t e;
          e = exp_rd.pop_front();
          chk("rd_both",  bus.rvalid0 & bus.rvalid1, 0);
          chk("rd_who",   bus.rvalid1, e.who);
          chk("rd_data",  e.who ? bus.rdata1 : bus.rdata0, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_mis=%0d", n_mis);
    $fatal(1);
  end

  initial begin
    drive(0, 0, 0, 8'd0, 8'd0, 0, 0, 0, 8'd0, 8'd0);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single CPU read of address 129 from IDLE
    push_acc(0, 0, 8'd129, 8'd0);
    push_rd(0, 8'd2);
    chk("t1_gnt0_idle", bus.gnt0, 0);
    cyc(1, 0, 0, 8'd129, 8'd0, 0, 0, 0, 8'd0, 8'd0);
    chk("t1_gnt0_n1", bus.gnt0, 1);
    chk("t1_gnt1_n1", bus.gnt1, 0);
    cyc(1, 0, 0, 8'd129, 8'd0, 0, 0, 0, 8'd0, 8'd0);
    chk("t1_rvalid0_n2", bus.rvalid0, 1);
    chk("t1_rdata0_n2",  bus.rdata0,  8'd2);
    idle(2);

    // Loader writes F0 to 139, CPU reads it back with a seamless handover
    push_acc(1, 1, 8'd139, 8'hF0);
    push_acc(0, 0, 8'd139, 8'd0);
    push_rd(0, 8'hF0);
    cyc(0, 0, 0, 8'd0,   8'd0, 1, 0, 1, 8'd139, 8'hF0);
    chk("t2_gnt1", bus.gnt1, 1);
    cyc(1, 0, 0, 8'd139, 8'd0, 1, 0, 1, 8'd139, 8'hF0);
    chk("t2_handover_gnt0", bus.gnt0, 1);
    chk("t2_handover_gnt1", bus.gnt1, 0);
    cyc(1, 0, 0, 8'd139, 8'd0, 0, 0, 0, 8'd0,   8'd0);
    idle(2);

    // Unlocked contention, both requests held for 6 cycles
    do_reset();
`ifdef SPM_ARB_ROUND_ROBIN_EN
    push_acc(0, 0, 8'd10, 8'd0); push_rd(0, 8'd10);
    push_acc(1, 0, 8'd20, 8'd0); push_rd(1, 8'd20);
    push_acc(0, 0, 8'd10, 8'd0); push_rd(0, 8'd10);
    push_acc(1, 0, 8'd20, 8'd0); push_rd(1, 8'd20);
    push_acc(0, 0, 8'd10, 8'd0); push_rd(0, 8'd10);
`else
    for (int i = 0; i < 5; i++) begin
      push_acc(0, 0, 8'd10, 8'd0);
      push_rd(0, 8'd10);
    end
`endif
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 8'd10, 8'd0, 1, 0, 0, 8'd20, 8'd0);
    idle(2);

    // Locked opcode+operand fetch by the CPU while the loader waits
    do_reset();
    push_acc(0, 0, 8'd0,  8'd0); push_rd(0, 8'd0);
    push_acc(0, 0, 8'd1,  8'd0); push_rd(0, 8'd1);
    push_acc(1, 0, 8'd30, 8'd0); push_rd(1, 8'd30);
    cyc(1, 1, 0, 8'd0, 8'd0, 1, 0, 0, 8'd30, 8'd0);
    cyc(1, 1, 0, 8'd0, 8'd0, 1, 0, 0, 8'd30, 8'd0);
    chk("t4_locked_gnt0", bus.gnt0, 1);
    chk("t4_locked_gnt1", bus.gnt1, 0);
    cyc(1, 0, 0, 8'd1, 8'd0, 1, 0, 0, 8'd30, 8'd0);
    cyc(0, 0, 0, 8'd0, 8'd0, 1, 0, 0, 8'd30, 8'd0);
    chk("t4_ldr_gnt1", bus.gnt1, 1);
    cyc(0, 0, 0, 8'd0, 8'd0, 1, 0, 0, 8'd30, 8'd0);
    idle(2);

    // Lock starvation bound: 4 locked CPU accesses, then forced handover
    do_reset();
    push_acc(0, 0, 8'd40, 8'd0); push_rd(0, 8'd40);
    push_acc(0, 0, 8'd41, 8'd0); push_rd(0, 8'd41);
    push_acc(0, 0, 8'd42, 8'd0); push_rd(0, 8'd42);
    push_acc(0, 0, 8'd43, 8'd0); push_rd(0, 8'd43);
    push_acc(1, 0, 8'd50, 8'd0); push_rd(1, 8'd50);
    cyc(1, 1, 0, 8'd40, 8'd0, 1, 0, 0, 8'd50, 8'd0);
    cyc(1, 1, 0, 8'd40, 8'd0, 1, 0, 0, 8'd50, 8'd0);
    cyc(1, 1, 0, 8'd41, 8'd0, 1, 0, 0, 8'd50, 8'd0);
    cyc(1, 1, 0, 8'd42, 8'd0, 1, 0, 0, 8'd50, 8'd0);
    chk("t5_gnt0_4th", bus.gnt0, 1);
    cyc(1, 1, 0, 8'd43, 8'd0, 1, 0, 0, 8'd50, 8'd0);
    chk("t5_forced_gnt0", bus.gnt0, 0);
    chk("t5_forced_gnt1", bus.gnt1, 1);
    cyc(1, 1, 0, 8'd44, 8'd0, 1, 0, 0, 8'd50, 8'd0);
    idle(2);

    // Reset while a CPU read response is pending
    push_acc(0, 0, 8'd7, 8'd0);
    cyc(1, 0, 0, 8'd7, 8'd0, 0, 0, 0, 8'd0, 8'd0);
    cyc(1, 0, 0, 8'd7, 8'd0, 0, 0, 0, 8'd0, 8'd0);
    chk("t6_rvalid0_pending", bus.rvalid0, 1);
    drive(0, 0, 0, 8'd0, 8'd0, 0, 0, 0, 8'd0, 8'd0);
    rst = 1'b1;
    #1;
    chk_zero("t6_async");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);
    chk("t6_rvalid0_after", bus.rvalid0, 0);

    chk("acc_queue_left", exp_acc.size(), 0);
    chk("rd_queue_left",  exp_rd.size(),  0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
